// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: core has priority, host gets bounded bursts with starvation protection.
// Optional stall_cnt output is built when ARB_PERF_CNT_EN is defined.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_BURST  = 8,
    parameter int STARVE_LIM = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_last,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int BEAT_W   = (MAX_BURST  > 1) ? $clog2(MAX_BURST)  : 1;
    localparam int STARVE_W = (STARVE_LIM > 1) ? $clog2(STARVE_LIM) : 1;
    localparam logic [BEAT_W-1:0]   BEAT_MAX   = BEAT_W'(MAX_BURST - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIM - 1);

    typedef enum logic {OWN_CORE, OWN_HOST} state_t;

    state_t              state, state_next;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [STARVE_W-1:0] starve_cnt;
    logic                beat;

    assign host_gnt   = (state == OWN_HOST);
    assign core_rdata = mem_rdata;

    always_comb begin
        state_next = state;
        beat       = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = core_addr;
        mem_wdata  = core_wdata;
        core_stall = 1'b0;
        unique case (state)
            OWN_CORE: begin
                mem_we = core_req & core_we;
                if (host_req && (!core_req || starve_cnt == STARVE_MAX))
                    state_next = OWN_HOST;
            end
            OWN_HOST: begin
                beat       = host_req;
                mem_we     = host_req & host_we;
                mem_addr   = host_addr;
                mem_wdata  = host_wdata;
                core_stall = core_req;
                if (!host_req || host_last || beat_cnt == BEAT_MAX)
                    state_next = OWN_CORE;
            end
        endcase
        // A reset cycle must never write memory or report a stall.
        if (!rst) begin
            mem_we     = 1'b0;
            core_stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= OWN_CORE;
            beat_cnt    <= '0;
            starve_cnt  <= '0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            state       <= state_next;
            host_rvalid <= beat & ~host_we;
            if (beat && !host_we)
                host_rdata <= mem_rdata;

            if (state == OWN_HOST && state_next == OWN_CORE)
                beat_cnt <= '0;
            else if (beat)
                beat_cnt <= beat_cnt + 1'b1;

            if (state == OWN_CORE && state_next == OWN_CORE && host_req && core_req)
                starve_cnt <= starve_cnt + 1'b1;
            else
                starve_cnt <= '0;
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst)
            stall_cnt <= '0;
        else if (core_stall && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: core-only, host bursts, burst cap, starvation, host read, reset.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_stall;
    logic        host_req, host_we, host_last;
    logic [31:0] host_addr, host_wdata;
    logic        host_gnt, host_rvalid;
    logic [31:0] host_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_last  (host_last),
        .host_gnt   (host_gnt),
        .host_rdata (host_rdata),
        .host_rvalid(host_rvalid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef ARB_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b0;
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h0; core_wdata = 32'h0;
        host_req = 1'b0; host_we = 1'b0; host_addr = 32'h0; host_wdata = 32'h0;
        host_last = 1'b0; mem_rdata = 32'h0;

        next_cycle();
        next_cycle();
        settle();
        chk("rst_mem_we", mem_we, 0);
        chk("rst_stall", core_stall, 0);
        chk("rst_gnt", host_gnt, 0);
        chk("rst_rvalid", host_rvalid, 0);
        chk("rst_rdata", host_rdata, 0);
`ifdef ARB_PERF_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 0);
`endif

        // Core-only store
        next_cycle();
        rst = 1'b1;
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h40; core_wdata = 32'hA5;
        mem_rdata = 32'h1234;
        settle();
        chk("core_we", mem_we, 1);
        chk("core_addr", mem_addr, 32'h40);
        chk("core_wdata", mem_wdata, 32'hA5);
        chk("core_stall0", core_stall, 0);
        chk("core_gnt0", host_gnt, 0);
        chk("core_rdata", core_rdata, 32'h1234);
        next_cycle();
        core_we = 1'b0;
        settle();
        chk("core_load_we", mem_we, 0);
        chk("core_load_stall", core_stall, 0);

        // Host 4-beat write burst with core idle
        next_cycle();
        core_req = 1'b0; mem_rdata = 32'h0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 32'h100; host_wdata = 32'h1;
        settle();
        chk("burst_c0_gnt", host_gnt, 0);
        chk("burst_c0_we", mem_we, 0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            host_addr = 32'h100 + 32'(4 * i);
            host_wdata = 32'(i + 1);
            host_last = (i == 3);
            settle();
            chk("burst_gnt", host_gnt, 1);
            chk("burst_we", mem_we, 1);
            chk("burst_addr", mem_addr, 32'h100 + 64'(4 * i));
            chk("burst_wdata", mem_wdata, 64'(i + 1));
        end
        next_cycle();
        host_req = 1'b0; host_last = 1'b0;
        settle();
        chk("burst_c5_gnt", host_gnt, 0);

        // 12-beat burst, never host_last: cap at 8, then regrant
        next_cycle();
        host_req = 1'b1; host_we = 1'b1; host_addr = 32'h200;
        settle();
        chk("cap_c0_gnt", host_gnt, 0);
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            host_addr = 32'h200 + 32'(4 * k);
            settle();
            chk("cap_gnt_a", host_gnt, 1);
            chk("cap_addr_a", mem_addr, 32'h200 + 64'(4 * k));
        end
        next_cycle();
        settle();
        chk("cap_window_gnt", host_gnt, 0);
        chk("cap_window_we", mem_we, 0);
        for (int k = 8; k < 12; k++) begin
            next_cycle();
            host_addr = 32'h200 + 32'(4 * k);
            settle();
            chk("cap_gnt_b", host_gnt, 1);
            chk("cap_we_b", mem_we, 1);
            chk("cap_addr_b", mem_addr, 32'h200 + 64'(4 * k));
        end
        next_cycle();
        host_req = 1'b0;
        settle();
        chk("cap_idle_gnt", host_gnt, 1);
        chk("cap_idle_we", mem_we, 0);
        next_cycle();
        settle();
        chk("cap_end_gnt", host_gnt, 0);

        // Starvation: both requesters held high
        next_cycle();
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h44;
        host_req = 1'b1; host_we = 1'b1; host_addr = 32'h300; host_wdata = 32'h77;
        settle();
        for (int w = 0; w < 16; w++) begin
            if (w > 0) next_cycle();
            settle();
            chk("starve_wait_gnt", host_gnt, 0);
            chk("starve_wait_stall", core_stall, 0);
        end
        next_cycle();
        settle();
        chk("starve_gnt", host_gnt, 1);
        chk("starve_stall", core_stall, 1);
        chk("starve_we", mem_we, 1);
        chk("starve_addr", mem_addr, 32'h300);
        next_cycle();
        host_last = 1'b1;
        settle();
        chk("starve_gnt2", host_gnt, 1);
        chk("starve_stall2", core_stall, 1);
        next_cycle();
        host_req = 1'b0; host_last = 1'b0;
        settle();
        chk("resume_gnt", host_gnt, 0);
        chk("resume_stall", core_stall, 0);
        chk("resume_addr", mem_addr, 32'h44);
`ifdef ARB_PERF_CNT_EN
        chk("stall_cnt2", stall_cnt, 2);
`endif

        // Host read of 0x80
        next_cycle();
        core_req = 1'b0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 32'h80; host_last = 1'b1;
        settle();
        chk("rd_c0_gnt", host_gnt, 0);
        next_cycle();
        mem_rdata = 32'hDEADBEEF;
        settle();
        chk("rd_gnt", host_gnt, 1);
        chk("rd_we", mem_we, 0);
        chk("rd_addr", mem_addr, 32'h80);
        chk("rd_rvalid_early", host_rvalid, 0);
        next_cycle();
        host_req = 1'b0; host_last = 1'b0; mem_rdata = 32'h0;
        settle();
        chk("rd_rvalid", host_rvalid, 1);
        chk("rd_rdata", host_rdata, 32'hDEADBEEF);
        chk("rd_gnt_after", host_gnt, 0);
        next_cycle();
        settle();
        chk("rd_rvalid_drop", host_rvalid, 0);
        chk("rd_rdata_hold", host_rdata, 32'hDEADBEEF);

        // Reset on beat 3 of a write burst
        next_cycle();
        host_req = 1'b1; host_we = 1'b1; host_addr = 32'h500; host_wdata = 32'h9;
        settle();
        chk("rb_c0_gnt", host_gnt, 0);
        for (int b = 0; b < 2; b++) begin
            next_cycle();
            settle();
            chk("rb_gnt", host_gnt, 1);
            chk("rb_we", mem_we, 1);
        end
        next_cycle();
        rst = 1'b0; core_req = 1'b1;
        settle();
        chk("rb_rst_we", mem_we, 0);
        chk("rb_rst_stall", core_stall, 0);
        next_cycle();
        rst = 1'b1; core_req = 1'b0;
        settle();
        chk("rb_post_gnt", host_gnt, 0);
        chk("rb_post_rvalid", host_rvalid, 0);
        chk("rb_post_rdata", host_rdata, 0);
        chk("rb_post_we", mem_we, 0);
`ifdef ARB_PERF_CNT_EN
        chk("rb_stall_cnt", stall_cnt, 0);
`endif
        next_cycle();
        settle();
        chk("rb_regrant", host_gnt, 1);
        chk("rb_regrant_we", mem_we, 1);

        next_cycle();
        host_req = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish, expected finish before 50000");
        $fatal(1);
    end

endmodule
